// File: rtl/wrapped_32x16_ram.sv
// 32 x 16 single-port RAM with per-slice INIT preload, registered write-first read.
// Memory contents are preloaded at time zero and are not cleared by reset.
module wrapped_32x16_ram #(
    parameter logic [63:0] INIT_A = 64'h0,
    parameter logic [63:0] INIT_B = 64'h0,
    parameter logic [63:0] INIT_C = 64'h0,
    parameter logic [63:0] INIT_D = 64'h0,
    parameter logic [63:0] INIT_E = 64'h0,
    parameter logic [63:0] INIT_F = 64'h0,
    parameter logic [63:0] INIT_G = 64'h0,
    parameter logic [63:0] INIT_H = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout
);

    // Slice k supplies bits [2k+1:2k] of every word; word a lives at INIT bits [2a+1:2a].
    function automatic logic [31:0][15:0] f_init_mem();
        logic [7:0][63:0]  w_slices;
        logic [31:0][15:0] w_mem;
        w_slices = {INIT_H, INIT_G, INIT_F, INIT_E, INIT_D, INIT_C, INIT_B, INIT_A};
        w_mem    = '0;
        for (int unsigned a = 0; a < 32; a++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                w_mem[a][2*k +: 2] = w_slices[k][2*a +: 2];
            end
        end
        return w_mem;
    endfunction

    logic [31:0][15:0] r_mem = f_init_mem();
    logic [15:0]       r_dout;

    always_ff @(posedge clock) begin
        if (!reset && we) begin
            r_mem[addr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
        end else if (we) begin
            r_dout <= din;
        end else begin
            r_dout <= r_mem[addr];
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_wrapped_32x16_ram.sv
// Self-checking bench for wrapped_32x16_ram: directed spec steps, then random
// traffic compared against an array-based model of the memory.
module tb_wrapped_32x16_ram;

    localparam logic [63:0] P_A = 64'h0000ffff0000ffff;
    localparam logic [63:0] P_B = 64'hffff0000ffff0000;
    localparam logic [63:0] P_C = 64'h00ff00ff00ff00ff;
    localparam logic [63:0] P_D = 64'hff00ff00ff00ff00;
    localparam logic [63:0] P_E = 64'h5555555555555555;
    localparam logic [63:0] P_F = 64'haaaaaaaaaaaaaaaa;
    localparam logic [63:0] P_G = 64'h1ec22a79414237db;
    localparam logic [63:0] P_H = 64'h425406d2470339cb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        we    = 1'b0;
    logic [4:0]  addr  = '0;
    logic [15:0] din   = '0;
    logic [15:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_m [32];
    logic [15:0] dout_m;

    wrapped_32x16_ram #(
        .INIT_A(P_A), .INIT_B(P_B), .INIT_C(P_C), .INIT_D(P_D),
        .INIT_E(P_E), .INIT_F(P_F), .INIT_G(P_G), .INIT_H(P_H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle of traffic; the model then decides what dout must be.
    task automatic step(input logic w, input logic [4:0] a, input logic [15:0] d, input string tag);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clock);
        #1;
        if (w === 1'b1) begin
            mem_m[a] = d;
            dout_m   = d;
        end else begin
            dout_m = mem_m[a];
        end
        check(tag, dout, dout_m);
    endtask

    task automatic build_model();
        logic [63:0] slices [8];
        slices = '{P_A, P_B, P_C, P_D, P_E, P_F, P_G, P_H};
        for (int a = 0; a < 32; a++) begin
            mem_m[a] = '0;
            for (int k = 0; k < 8; k++) begin
                mem_m[a] = mem_m[a] | 16'(((slices[k] >> (2 * a)) & 64'h3) << (2 * k));
            end
        end
    endtask

    initial begin
        build_model();

        // Asynchronous reset with no clock edge yet
        #1 reset = 1'b1;
        #1 check("reset_async", dout, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 5'd0, 16'h0, "read0");
        check("read0_const", dout, 16'hF933);

        step(1'b0, 5'd1, 16'h0, "read1");
        check("read1_const", dout, 16'hA933);
        step(1'b0, 5'd7, 16'h0, "read7");
        check("read7_const", dout, 16'h09C3);
        step(1'b0, 5'd8, 16'h0, "read8");
        check("read8_const", dout, 16'hE93C);

        step(1'b1, 5'd7, 16'hB70D, "wr7_first");
        check("wr7_const", dout, 16'hB70D);
        step(1'b0, 5'd7, 16'h0, "rd7_after_wr");
        check("rd7_const", dout, 16'hB70D);

        step(1'b1, 5'd31, 16'h1234, "wr31");
        step(1'b1, 5'd0,  16'hFFFF, "wr0");
        step(1'b0, 5'd31, 16'h0, "rd31");
        check("rd31_const", dout, 16'h1234);
        step(1'b0, 5'd0, 16'h0, "rd0");
        check("rd0_const", dout, 16'hFFFF);

        // Contents survive a reset pulse
        step(1'b1, 5'd3, 16'hABCD, "wr3");
        we = 1'b0;
        reset = 1'b1;
        #1 check("reset_pulse", dout, 16'h0000);
        dout_m = '0;
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 5'd3, 16'h0, "rd3_after_reset");
        check("rd3_const", dout, 16'hABCD);

        // Write attempted under reset must be ignored
        @(negedge clock);
        reset = 1'b1;
        we    = 1'b1;
        addr  = 5'd5;
        din   = 16'h0000;
        @(posedge clock);
        #1 check("reset_hold_dout", dout, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        we    = 1'b0;
        step(1'b0, 5'd5, 16'h0, "rd5_suppressed");
        check("rd5_const", dout, 16'h99C3);

        // Random back-to-back traffic, occasionally with an unknown write enable
        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic [4:0]  a;
            logic [15:0] d;
            a = 5'($urandom_range(0, 31));
            d = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       w = 1'bx;
                1, 2, 3: w = 1'b1;
                default: w = 1'b0;
            endcase
            step(w, a, d, "random");
        end

        // Full read-back sweep of the final memory image
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 5'(a), 16'h0, "sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
